ps2_kbd_decode: RTL and testbench
=================================

PS2_KBD_DECODE -- requirements
Module: ps2_kbd_decode

Interface
REQ-001 SHALL have parameter DEPTH, default 8, event FIFO depth in entries (power of 2, 2..64).
REQ-002 SHALL have port clk  in  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rdy  in  1  upstream PS/2 receiver has a byte available.
REQ-005 SHALL have port data  in  8  upstream byte, valid while rdy=1.
REQ-006 SHALL have port done  out  1  byte consumed this cycle (upstream pops on rdy&done).
REQ-007 SHALL have port ev_valid  out  1  event FIFO non-empty.
REQ-008 SHALL have port ev_code  out  8  head event scancode.
REQ-009 SHALL have port ev_break  out  1  head event is key release.
REQ-010 SHALL have port ev_ext  out  1  head event had E0/E1 prefix.
REQ-011 SHALL have port ev_pop  in  1  consume head event.
REQ-012 SHALL have port mods  out  7  {caps, ralt, lalt, rctrl, lctrl, rshift, lshift}.
REQ-013 SHALL have port overrun  out  1  sticky: event dropped on full FIFO.
REQ-014 SHALL have port err  out  1  sticky: protocol/device error byte seen.
REQ-015 SHALL have port err_clr  in  1  clears err and overrun.

Function
REQ-016 SHALL drive done combinationally = rdy; data sampled at the same clock edge; one byte per cycle max, never stalls.
REQ-017 SHALL implement FSM states IDLE, BRK, EXT, EXTBRK, PAUSE, plus 3-bit skip counter.
REQ-018 IDLE: E0->EXT; F0->BRK; E1->PAUSE, cnt=7; AA/FA/EE ignored; 00/FF/FC/FD set err; other -> emit make, ext=0.
REQ-019 EXT: F0->EXTBRK; 12/59 (fake shift) discarded ->IDLE; E0/E1 set err ->IDLE; other -> emit make, ext=1, ->IDLE.
REQ-020 BRK: F0/E0/E1 set err ->IDLE; other -> emit break, ext=0, ->IDLE.
REQ-021 EXTBRK: 12/59 discarded; F0/E0/E1 set err; other -> emit break, ext=1; all ->IDLE.
REQ-022 PAUSE: each byte decrements cnt; byte taking cnt 1->0 emits make code 77, ext=1, ->IDLE; content of skipped bytes ignored.
REQ-023 Emitted event SHALL be written to FIFO at the consuming edge; ev_valid rises next cycle when FIFO was empty (latency 1).
REQ-024 FIFO full and write without pop: event dropped, overrun set; full with pop same cycle: write accepted.
REQ-025 ev_pop while empty SHALL be ignored; head outputs hold when empty is irrelevant but SHALL not change FIFO state.
REQ-026 Modifiers SHALL update on every emitted event, even if dropped: code 12 lshift, 59 rshift, 14 lctrl(ext=0)/rctrl(ext=1), 11 lalt(ext=0)/ralt(ext=1); make sets, break clears.
REQ-027 Caps SHALL toggle on 58 make only when caps_held=0; make sets caps_held, break clears it (typematic repeats do not toggle).
REQ-028 err_clr SHALL clear err/overrun; a set condition in the same cycle wins.

Reset
REQ-029 On rst: FSM IDLE, cnt=0, FIFO empty, ev_valid=0, mods=0, caps_held=0, err=0, overrun=0; done follows rdy (combinational).
REQ-030 Reset mid-sequence SHALL discard pending prefix; next byte decoded from IDLE.

Verification
REQ-031 Bytes 1C, F0 1C -> events {1C,brk0,ext0} then {1C,brk1,ext0}; done high each rdy cycle.
REQ-032 E0 75, E0 F0 75, E0 12 -> {75,0,1}, {75,1,1}; E0 12 yields no event, mods unchanged.
REQ-033 E1 14 77 E1 F0 14 F0 77 -> exactly one event {77,0,1}; lctrl unchanged.
REQ-034 12 make -> mods[0]=1; 58,58,F0 58 -> caps=1 (one toggle); 58 again -> caps=0.
REQ-035 DEPTH=8, 9 makes without pop -> 8 stored, overrun=1; err_clr -> overrun=0; byte FF -> err=1.
REQ-036 F0 then rst pulse then 1C -> single make event {1C,0,0}.

Source files
------------

// File: rtl/ps2_kbd_decode.sv
// PS/2 set-2 scancode decoder: strips E0/E1/F0 prefixes, queues key events in a
// small FIFO and tracks modifier/caps-lock state.
module ps2_kbd_decode #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    input  logic [7:0] data,
    output logic       done,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_break,
    output logic       ev_ext,
    input  logic       ev_pop,
    output logic [6:0] mods,
    output logic       overrun,
    output logic       err,
    input  logic       err_clr
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, BRK, EXT, EXTBRK, PAUSE} state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic       emit;
    logic [7:0] em_code;
    logic       em_brk;
    logic       em_ext;
    logic       err_set;

    assign done = rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        emit    = 1'b0;
        em_code = data;
        em_brk  = 1'b0;
        em_ext  = 1'b0;
        err_set = 1'b0;
        if (rdy) begin
            case (state_q)
                IDLE: begin
                    case (data)
                        8'hE0: state_d = EXT;
                        8'hF0: state_d = BRK;
                        8'hE1: begin
                            state_d = PAUSE;
                            cnt_d   = 3'd7;
                        end
                        8'hAA, 8'hFA, 8'hEE: ;
                        8'h00, 8'hFF, 8'hFC, 8'hFD: err_set = 1'b1;
                        default: emit = 1'b1;
                    endcase
                end
                EXT: begin
                    state_d = IDLE;
                    case (data)
                        8'hF0: state_d = EXTBRK;
                        8'h12, 8'h59: ;
                        8'hE0, 8'hE1: err_set = 1'b1;
                        default: begin
                            emit   = 1'b1;
                            em_ext = 1'b1;
                        end
                    endcase
                end
                BRK: begin
                    state_d = IDLE;
                    case (data)
                        8'hF0, 8'hE0, 8'hE1: err_set = 1'b1;
                        default: begin
                            emit   = 1'b1;
                            em_brk = 1'b1;
                        end
                    endcase
                end
                EXTBRK: begin
                    state_d = IDLE;
                    case (data)
                        8'h12, 8'h59: ;
                        8'hF0, 8'hE0, 8'hE1: err_set = 1'b1;
                        default: begin
                            emit   = 1'b1;
                            em_brk = 1'b1;
                            em_ext = 1'b1;
                        end
                    endcase
                end
                PAUSE: begin
                    // Pause/Break body bytes are skipped; the last one produces the event.
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        emit    = 1'b1;
                        em_code = 8'h77;
                        em_ext  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    logic [9:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        empty, full, pop_ok, push, drop;

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok = ev_pop && !empty;
    assign push   = emit && (!full || pop_ok);
    assign drop   = emit && full && !pop_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {em_ext, em_brk, em_code};
    end

    assign ev_valid = !empty;
    assign {ev_ext, ev_break, ev_code} = mem_q[rd_ptr_q[AW-1:0]];

    logic [6:0] mods_q, mods_d;
    logic       held_q, held_d;
    logic       err_q, err_d, ovr_q, ovr_d;

    // Modifier state follows decoded events even when the FIFO drops them.
    always_comb begin
        mods_d = mods_q;
        held_d = held_q;
        if (emit) begin
            case (em_code)
                8'h12: mods_d[0] = !em_brk;
                8'h59: mods_d[1] = !em_brk;
                8'h14: if (em_ext) mods_d[3] = !em_brk; else mods_d[2] = !em_brk;
                8'h11: if (em_ext) mods_d[5] = !em_brk; else mods_d[4] = !em_brk;
                8'h58: begin
                    if (!em_brk) begin
                        if (!held_q) mods_d[6] = !mods_q[6];
                        held_d = 1'b1;
                    end else begin
                        held_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign err_d = err_set | (err_q & ~err_clr);
    assign ovr_d = drop | (ovr_q & ~err_clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mods_q <= '0;
            held_q <= 1'b0;
            err_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            mods_q <= mods_d;
            held_q <= held_d;
            err_q  <= err_d;
            ovr_q  <= ovr_d;
        end
    end

    assign mods    = mods_q;
    assign err     = err_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_ps2_kbd_decode.sv
// Self-checking bench for ps2_kbd_decode: directed scenarios with literal
// expectations, then randomized bytes checked against a prefix-flag model.
module tb_ps2_kbd_decode;

    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rdy = 1'b0;
    logic [7:0] data = '0;
    logic       done;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_break;
    logic       ev_ext;
    logic       ev_pop = 1'b0;
    logic [6:0] mods;
    logic       overrun;
    logic       err;
    logic       err_clr = 1'b0;

    ps2_kbd_decode #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .data(data), .done(done),
        .ev_valid(ev_valid), .ev_code(ev_code), .ev_break(ev_break), .ev_ext(ev_ext),
        .ev_pop(ev_pop), .mods(mods), .overrun(overrun), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ev_t;

    ev_t        q[$];
    bit         m_ext, m_brk, m_held, m_err, m_ovr;
    int         m_pause;
    logic [6:0] m_mods;
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ext = 0; m_brk = 0; m_pause = 0;
        m_held = 0; m_err = 0; m_ovr = 0; m_mods = '0;
    endtask

    task automatic model_step();
        bit  emit, es, os, prefix;
        ev_t e;
        emit = 0; es = 0; os = 0;
        e.code = data; e.brk = m_brk; e.ext = m_ext;
        if (rdy) begin
            prefix = m_ext || m_brk;
            if (m_pause > 0) begin
                m_pause--;
                if (m_pause == 0) begin
                    emit = 1; e.code = 8'h77; e.brk = 0; e.ext = 1;
                end
            end else begin
                case (data)
                    8'hE0, 8'hE1: begin
                        if (prefix) begin es = 1; m_ext = 0; m_brk = 0; end
                        else if (data == 8'hE0) m_ext = 1;
                        else m_pause = 7;
                    end
                    8'hF0: begin
                        if (m_brk) begin es = 1; m_ext = 0; m_brk = 0; end
                        else m_brk = 1;
                    end
                    8'h12, 8'h59: begin
                        if (!m_ext) emit = 1;
                        m_ext = 0; m_brk = 0;
                    end
                    8'hAA, 8'hFA, 8'hEE: begin
                        if (prefix) emit = 1;
                        m_ext = 0; m_brk = 0;
                    end
                    8'h00, 8'hFF, 8'hFC, 8'hFD: begin
                        if (prefix) emit = 1; else es = 1;
                        m_ext = 0; m_brk = 0;
                    end
                    default: begin
                        emit = 1; m_ext = 0; m_brk = 0;
                    end
                endcase
            end
        end
        if (emit) begin
            case (e.code)
                8'h12: m_mods[0] = !e.brk;
                8'h59: m_mods[1] = !e.brk;
                8'h14: m_mods[e.ext ? 3 : 2] = !e.brk;
                8'h11: m_mods[e.ext ? 5 : 4] = !e.brk;
                8'h58: begin
                    if (!e.brk && !m_held) m_mods[6] = !m_mods[6];
                    m_held = !e.brk;
                end
                default: ;
            endcase
        end
        if (ev_pop && q.size() > 0) void'(q.pop_front());
        if (emit) begin
            if (q.size() < DEPTH) q.push_back(e);
            else os = 1;
        end
        m_err = es | (m_err & !err_clr);
        m_ovr = os | (m_ovr & !err_clr);
    endtask

    always @(negedge clk) begin
        chk("done", 16'(done), 16'(rdy));
        chk("ev_valid", 16'(ev_valid), 16'(q.size() != 0));
        if (q.size() != 0)
            chk("head", 16'({ev_ext, ev_break, ev_code}), 16'({q[0].ext, q[0].brk, q[0].code}));
        chk("mods", 16'(mods), 16'(m_mods));
        chk("err", 16'(err), 16'(m_err));
        chk("overrun", 16'(overrun), 16'(m_ovr));
    end

    task automatic cyc(input bit r, input logic [7:0] d, input bit p, input bit c);
        rdy = r; data = d; ev_pop = p; err_clr = c;
        @(posedge clk);
        if (!rst) model_step();
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1, b, 0, 0);
    endtask

    task automatic do_reset();
        rdy = 0; ev_pop = 0; err_clr = 0;
        rst = 1;
        model_reset();
        @(posedge clk);
        #2;
        rst = 0;
    endtask

    task automatic expect_ev(input string name, input logic [7:0] c, input bit b, input bit x);
        chk({name, "_valid"}, 16'(ev_valid), 16'd1);
        chk({name, "_dut"}, 16'({ev_ext, ev_break, ev_code}), 16'({x, b, c}));
        if (q.size() > 0)
            chk({name, "_model"}, 16'({q[0].ext, q[0].brk, q[0].code}), 16'({x, b, c}));
        else
            chk({name, "_model_empty"}, 16'd1, 16'd0);
        cyc(0, 8'h00, 1, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && ev_valid; i++) cyc(0, 8'h00, 1, 0);
        chk("drain_empty", 16'(ev_valid), 16'd0);
    endtask

    logic [7:0] pool [16] = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'h14, 8'h11, 8'h58,
                              8'hAA, 8'hFA, 8'h00, 8'hFF, 8'h1C, 8'h75, 8'h77, 8'h00};

    initial begin
        int pops;
        logic [7:0] b;
        model_reset();
        #1 rst = 1;
        repeat (2) @(posedge clk);
        #2 rst = 0;

        chk("reset_valid", 16'(ev_valid), 16'd0);
        chk("reset_mods", 16'(mods), 16'd0);
        chk("reset_err_ovr", 16'({err, overrun}), 16'd0);

        send(8'h1C);
        chk("latency1", 16'(ev_valid), 16'd1);
        send(8'hF0); send(8'h1C);
        cyc(0, 8'h00, 0, 0);
        expect_ev("make_1c", 8'h1C, 0, 0);
        expect_ev("break_1c", 8'h1C, 1, 0);
        chk("after_1c_empty", 16'(ev_valid), 16'd0);

        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'h12);
        cyc(0, 8'h00, 0, 0);
        expect_ev("ext_make", 8'h75, 0, 1);
        expect_ev("ext_break", 8'h75, 1, 1);
        chk("fake_shift_none", 16'(ev_valid), 16'd0);
        chk("fake_shift_mods", 16'(mods), 16'd0);

        foreach (pool[i]) ;
        begin
            logic [7:0] pseq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
            for (int i = 0; i < 8; i++) send(pseq[i]);
        end
        cyc(0, 8'h00, 0, 0);
        expect_ev("pause", 8'h77, 0, 1);
        chk("pause_single", 16'(ev_valid), 16'd0);
        chk("pause_lctrl", 16'(mods[2]), 16'd0);

        send(8'h12);
        cyc(0, 8'h00, 0, 0);
        chk("lshift_make", 16'(mods), 16'h01);
        send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
        cyc(0, 8'h00, 0, 0);
        chk("caps_once", 16'(mods), 16'h41);
        send(8'h58);
        cyc(0, 8'h00, 0, 0);
        chk("caps_again", 16'(mods), 16'h01);
        drain();

        do_reset();
        for (int i = 0; i < 9; i++) send(8'(8'h15 + i));
        cyc(0, 8'h00, 0, 0);
        chk("full_ovr", 16'({ev_valid, overrun, err}), 16'b110);
        chk("full_head", 16'(ev_code), 16'h15);
        cyc(0, 8'h00, 0, 1);
        chk("ovr_clr", 16'(overrun), 16'd0);
        send(8'hFF);
        cyc(0, 8'h00, 0, 0);
        chk("err_ff", 16'(err), 16'd1);
        pops = 0;
        for (int i = 0; i < DEPTH + 4 && ev_valid; i++) begin
            cyc(0, 8'h00, 1, 0);
            pops++;
        end
        chk("fifo_count", 16'(pops), 16'(DEPTH));

        do_reset();
        send(8'hF0);
        do_reset();
        send(8'h1C);
        cyc(0, 8'h00, 0, 0);
        expect_ev("rst_prefix", 8'h1C, 0, 0);
        chk("rst_prefix_single", 16'(ev_valid), 16'd0);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) < 3) begin
                do_reset();
            end else begin
                b = pool[$urandom_range(0, 15)];
                if ($urandom_range(0, 15) == 15) b = 8'($urandom);
                cyc($urandom_range(0, 3) != 0, b, $urandom_range(0, 9) < 4,
                    $urandom_range(0, 99) < 3);
            end
        end
        cyc(0, 8'h00, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
